// File: rtl/ibex_rvfi_ext_trace_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ibex_rvfi_ext_trace_sequencer
// Purpose  : Snapshots the RVFI extension sideband on each retired
//            instruction and serialises the snapshot as a fixed-format
//            record of 32-bit words on a valid/ready trace stream.
//            Record: HDR, MIP, MCYCLE_LO, MCYCLE_HI, then per counter
//            CNT_LO[i] (and CNT_HI[i] when INCLUDE_HIGH).
// Ports    : clk_i/rst_i           clock, synchronous active-high reset
//            enable_i              capture enable
//            rvfi_valid_i          capture strobe (instruction retired)
//            rvfi_ext_*_i          sideband snapshot inputs
//            trace_tdata_o/tvalid_o/tlast_o, trace_tready_i  trace stream
//            busy_o                record in flight
//            drop_total_o          saturating count of dropped captures
// Revision : 1.0  initial release
// ============================================================================
module ibex_rvfi_ext_trace_sequencer #(
    parameter int NUM_COUNTERS = 10,
    parameter bit INCLUDE_HIGH = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             rvfi_valid_i,
    input  logic [31:0]      rvfi_ext_mip_i,
    input  logic [6:0]       rvfi_ext_flags_i,
    input  logic [63:0]      rvfi_ext_mcycle_i,
    input  logic [9:0][31:0] rvfi_ext_mhpmcounters_i,
    input  logic [9:0][31:0] rvfi_ext_mhpmcountersh_i,
    output logic [31:0]      trace_tdata_o,
    output logic             trace_tvalid_o,
    input  logic             trace_tready_i,
    output logic             trace_tlast_o,
    output logic             busy_o,
    output logic [15:0]      drop_total_o
);

    localparam int         c_REC_LEN  = 4 + NUM_COUNTERS * (INCLUDE_HIGH ? 2 : 1);
    // BODY index of the final word (word L-1 of the record)
    localparam logic [4:0] c_LAST_IDX = 5'(c_REC_LEN - 2);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_HDR  = 2'd1;
    localparam logic [1:0] c_ST_BODY = 2'd2;

    logic [1:0]  r_state;
    logic [4:0]  r_idx;
    logic [7:0]  r_seq;
    logic [7:0]  r_win;
    logic [15:0] r_total;
    logic [31:0] r_hdr;
    logic [31:0] r_mip;
    logic [63:0] r_mcycle;
    logic [NUM_COUNTERS-1:0][31:0] r_cnt_lo;
    logic [NUM_COUNTERS-1:0][31:0] r_cnt_hi;

    logic        w_busy;
    logic        w_xfer;
    logic        w_last;
    logic        w_final;
    logic        w_strobe;
    logic        w_accept;
    logic        w_drop;
    logic [4:0]  w_k;
    logic [3:0]  w_sel;
    logic        w_hi;
    logic [31:0] w_word;
    logic        w_unused_cnt;

    assign w_busy   = (r_state != c_ST_IDLE);
    assign w_xfer   = w_busy && trace_tready_i;
    assign w_last   = (r_state == c_ST_BODY) && (r_idx == c_LAST_IDX);
    assign w_final  = w_last && w_xfer;
    assign w_strobe = rvfi_valid_i && enable_i;
    // A strobe coinciding with the final handshake starts the next record
    // without a bubble instead of being dropped.
    assign w_accept = w_strobe && (!w_busy || w_final);
    assign w_drop   = w_strobe && w_busy && !w_final;

    // Counter entries beyond NUM_COUNTERS (and high words when excluded)
    // are intentionally not consumed.
    assign w_unused_cnt = ^{rvfi_ext_mhpmcounters_i, rvfi_ext_mhpmcountersh_i};

    // Body word selection from the snapshot; index 0..2 are the fixed words.
    always_comb begin
        w_word = '0;
        w_k    = r_idx - 5'd3;
        w_sel  = '0;
        w_hi   = 1'b0;
        if (INCLUDE_HIGH) begin
            w_sel = w_k[4:1];
            w_hi  = w_k[0];
        end else begin
            w_sel = w_k[3:0];
        end
        case (r_idx)
            5'd0:    w_word = r_mip;
            5'd1:    w_word = r_mcycle[31:0];
            5'd2:    w_word = r_mcycle[63:32];
            default: begin
                for (int i = 0; i < NUM_COUNTERS; i++) begin
                    if (w_sel == 4'(i)) begin
                        w_word = w_hi ? r_cnt_hi[i] : r_cnt_lo[i];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= c_ST_IDLE;
            r_idx    <= '0;
            r_seq    <= '0;
            r_win    <= '0;
            r_total  <= '0;
            r_hdr    <= '0;
            r_mip    <= '0;
            r_mcycle <= '0;
            r_cnt_lo <= '0;
            r_cnt_hi <= '0;
        end else begin
            if (w_accept) begin
                // Header is frozen at accept so the drop count reported is
                // the one accumulated up to this capture.
                r_hdr    <= {8'hA5, r_seq, r_win, rvfi_ext_flags_i, INCLUDE_HIGH};
                r_win    <= '0;
                r_mip    <= rvfi_ext_mip_i;
                r_mcycle <= rvfi_ext_mcycle_i;
                for (int i = 0; i < NUM_COUNTERS; i++) begin
                    r_cnt_lo[i] <= rvfi_ext_mhpmcounters_i[i];
                    r_cnt_hi[i] <= INCLUDE_HIGH ? rvfi_ext_mhpmcountersh_i[i] : 32'h0;
                end
                r_state  <= c_ST_HDR;
                r_idx    <= '0;
            end else begin
                case (r_state)
                    c_ST_HDR: begin
                        if (w_xfer) begin
                            r_state <= c_ST_BODY;
                            r_idx   <= '0;
                        end
                    end
                    c_ST_BODY: begin
                        if (w_xfer) begin
                            if (w_last) begin
                                r_state <= c_ST_IDLE;
                                r_idx   <= '0;
                            end else begin
                                r_idx <= r_idx + 5'd1;
                            end
                        end
                    end
                    default: r_state <= c_ST_IDLE;
                endcase
            end

            if ((r_state == c_ST_HDR) && w_xfer) begin
                r_seq <= r_seq + 8'd1;
            end

            if (w_drop) begin
                if (r_win != 8'hFF) begin
                    r_win <= r_win + 8'd1;
                end
                if (r_total != 16'hFFFF) begin
                    r_total <= r_total + 16'd1;
                end
            end
        end
    end

    assign trace_tdata_o  = (r_state == c_ST_HDR)  ? r_hdr  :
                            (r_state == c_ST_BODY) ? w_word : 32'h0;
    assign trace_tvalid_o = w_busy;
    assign trace_tlast_o  = w_last;
    assign busy_o         = w_busy;
    assign drop_total_o   = r_total;

endmodule
`default_nettype wire

// File: tb/tb_ibex_rvfi_ext_trace_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibex_rvfi_ext_trace_sequencer
// Purpose  : Scoreboard bench for ibex_rvfi_ext_trace_sequencer. Two
//            instances (default config and NUM_COUNTERS=2/INCLUDE_HIGH=0)
//            share one stimulus stream; a record-level reference model
//            queues expected words, a monitor pops them on handshakes.
// Revision : 1.0  initial release
// ============================================================================
module tb_ibex_rvfi_ext_trace_sequencer;

    localparam int NC_A = 10;
    localparam int NC_B = 2;
    localparam int L_A  = 4 + NC_A * 2;
    localparam int L_B  = 4 + NC_B;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             valid;
    logic [31:0]      mip;
    logic [6:0]       flags;
    logic [63:0]      mcycle;
    logic [9:0][31:0] cnt;
    logic [9:0][31:0] cnth;
    logic             tready;

    logic [31:0] td_a, td_b;
    logic        tv_a, tv_b, tl_a, tl_b, bz_a, bz_b;
    logic [15:0] dt_a, dt_b;

    always #5 clk = ~clk;

    ibex_rvfi_ext_trace_sequencer #(.NUM_COUNTERS(NC_A), .INCLUDE_HIGH(1'b1)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .rvfi_valid_i(valid),
        .rvfi_ext_mip_i(mip), .rvfi_ext_flags_i(flags), .rvfi_ext_mcycle_i(mcycle),
        .rvfi_ext_mhpmcounters_i(cnt), .rvfi_ext_mhpmcountersh_i(cnth),
        .trace_tdata_o(td_a), .trace_tvalid_o(tv_a), .trace_tready_i(tready),
        .trace_tlast_o(tl_a), .busy_o(bz_a), .drop_total_o(dt_a)
    );

    ibex_rvfi_ext_trace_sequencer #(.NUM_COUNTERS(NC_B), .INCLUDE_HIGH(1'b0)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .rvfi_valid_i(valid),
        .rvfi_ext_mip_i(mip), .rvfi_ext_flags_i(flags), .rvfi_ext_mcycle_i(mcycle),
        .rvfi_ext_mhpmcounters_i(cnt), .rvfi_ext_mhpmcountersh_i(cnth),
        .trace_tdata_o(td_b), .trace_tvalid_o(tv_b), .trace_tready_i(tready),
        .trace_tlast_o(tl_b), .busy_o(bz_b), .drop_total_o(dt_b)
    );

    // ---------------- reference model state (per instance) ----------------
    int          errors = 0;
    int          checks = 0;
    bit          started = 1'b0;
    int          rem   [2];   // words of the current record not yet transferred
    logic [7:0]  seq_m [2];
    logic [7:0]  win_m [2];
    logic [15:0] tot_m [2];
    logic [32:0] qa [$];      // {tlast, tdata}
    logic [32:0] qb [$];
    bit          hold   [2];
    logic [31:0] hold_d [2];
    logic        hold_l [2];

    task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[inst%0d] t=%0t: got %0h, expected %0h", name, k, $time, act, exp);
        end
    endtask

    function automatic int rec_len(input int k);
        return (k == 0) ? L_A : L_B;
    endfunction

    // Build the expected record straight from the word-order rules.
    task automatic push_record(input int k);
        int          nc;
        logic [31:0] w [$];
        nc = (k == 0) ? NC_A : NC_B;
        w.push_back({8'hA5, seq_m[k], win_m[k], flags, (k == 0) ? 1'b1 : 1'b0});
        w.push_back(mip);
        w.push_back(mcycle[31:0]);
        w.push_back(mcycle[63:32]);
        for (int i = 0; i < nc; i++) begin
            w.push_back(cnt[i]);
            if (k == 0) w.push_back(cnth[i]);
        end
        for (int i = 0; i < w.size(); i++) begin
            if (k == 0) qa.push_back({(i == w.size() - 1), w[i]});
            else        qb.push_back({(i == w.size() - 1), w[i]});
        end
    endtask

    // Advance the model across the coming clock edge using the driven inputs.
    task automatic model_step();
        bit xfer, fin, strobe, acc, drp;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                rem[k] = 0; seq_m[k] = 0; win_m[k] = 0; tot_m[k] = 0;
                if (k == 0) qa.delete(); else qb.delete();
            end else begin
                xfer   = (rem[k] > 0) && tready;
                fin    = xfer && (rem[k] == 1);
                strobe = valid && en;
                acc    = strobe && ((rem[k] == 0) || fin);
                drp    = strobe && !acc;
                if (xfer && (rem[k] == rec_len(k))) seq_m[k] = seq_m[k] + 8'd1;
                if (xfer) rem[k] = rem[k] - 1;
                if (drp) begin
                    if (win_m[k] != 8'hFF)    win_m[k] = win_m[k] + 8'd1;
                    if (tot_m[k] != 16'hFFFF) tot_m[k] = tot_m[k] + 16'd1;
                end
                if (acc) begin
                    push_record(k);
                    win_m[k] = 0;
                    rem[k]   = rec_len(k);
                end
            end
        end
    endtask

    // ---------------- monitor ----------------
    task automatic mon(input int k, input logic tv, input logic tl, input logic [31:0] td,
                       input logic bz, input logic [15:0] dt);
        logic [32:0] e;
        bit          have;
        chk("tvalid", k, 64'(tv), 64'(rem[k] > 0));
        chk("busy", k, 64'(bz), 64'(rem[k] > 0));
        chk("drop_total", k, 64'(dt), 64'(tot_m[k]));
        if (hold[k]) begin
            chk("hold_tdata", k, 64'(td), 64'(hold_d[k]));
            chk("hold_tlast", k, 64'(tl), 64'(hold_l[k]));
        end
        if (tv && tready) begin
            have = 1'b0;
            e    = '0;
            if (k == 0) begin
                if (qa.size() > 0) begin have = 1'b1; e = qa.pop_front(); end
            end else begin
                if (qb.size() > 0) begin have = 1'b1; e = qb.pop_front(); end
            end
            if (!have) begin
                errors++; checks++;
                $display("FAIL unexpected_word[inst%0d] t=%0t: got %0h, expected no transfer", k, $time, td);
            end else begin
                chk("tdata", k, 64'(td), 64'(e[31:0]));
                chk("tlast", k, 64'(tl), 64'(e[32]));
            end
        end
        hold[k]   = tv && !tready && !rst;
        hold_d[k] = td;
        hold_l[k] = tl;
    endtask

    always @(negedge clk) begin
        if (started) begin
            mon(0, tv_a, tl_a, td_a, bz_a, dt_a);
            mon(1, tv_b, tl_b, td_b, bz_b, dt_b);
        end
    end

    // ---------------- stimulus ----------------
    task automatic randomize_inputs();
        mip    = $urandom;
        flags  = 7'($urandom);
        mcycle = {$urandom, $urandom};
        for (int i = 0; i < 10; i++) begin
            cnt[i]  = $urandom;
            cnth[i] = $urandom;
        end
    endtask

    task automatic step(input bit v, input bit e, input bit r, input bit rdy, input bit rnd);
        @(posedge clk);
        #1;
        rst = r; valid = v; en = e; tready = rdy;
        if (rnd) randomize_inputs();
        @(negedge clk);
        #1;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; valid = 1'b0; tready = 1'b0;
        mip = '0; flags = '0; mcycle = '0; cnt = '0; cnth = '0;
        hold[0] = 0; hold[1] = 0;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        started = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("reset_tdata", 0, 64'(td_a), 64'h0);
        chk("reset_tlast", 0, 64'(tl_a), 64'h0);
        chk("reset_tdata", 1, 64'(td_b), 64'h0);
        chk("reset_tlast", 1, 64'(tl_b), 64'h0);

        // Single directed capture
        mip = 32'h0000_0888; flags = 7'b1000001; mcycle = 64'h1_0000_0005;
        for (int i = 0; i < 10; i++) begin
            cnt[i] = 32'(i); cnth[i] = 32'h100 + 32'(i);
        end
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(30);

        // Backpressure 1,0,0,1 with inputs churning after accept
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b0, (i % 4 == 0) || (i % 4 == 3), 1'b1);
        idle(10);

        // Drops during a record, then two further records
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 30; i++) step((i == 2) || (i == 5) || (i == 8), 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(30);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(30);

        // Back-to-back: strobe held so every final handshake re-accepts
        for (int i = 0; i < 80; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(30);

        // Random traffic
        for (int i = 0; i < 3000; i++)
            step(($urandom % 4) == 0, ($urandom % 8) != 0, 1'b0, ($urandom % 3) != 0, 1'b1);
        idle(40);

        // Strobes with enable low: no record, no drop
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(5);

        // Reset mid-record, then fresh record must carry seq 0
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(30);

        // Sequence wrap: >300 records per instance
        for (int i = 0; i < 7300; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(30);

        // Drop counter saturation under permanent backpressure
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 65600; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("drop_total_sat", 0, 64'(dt_a), 64'hFFFF);
        chk("drop_total_sat", 1, 64'(dt_b), 64'hFFFF);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(30);

        chk("queue_drained", 0, 64'(qa.size()), 64'h0);
        chk("queue_drained", 1, 64'(qb.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
